// File: rtl/vmem_scanout_if.sv
// rtl/vmem_scanout_if.sv - framebuffer read port between scan-out (master) and video memory (slave)
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 15
`endif

interface vmem_scanout_if;
  logic [`VMEM_ADDRW-1:0] vmem_raddr_o;
  logic [2:0]             vmem_rdata_i;

  modport master (output vmem_raddr_o, input  vmem_rdata_i);
  modport slave  (input  vmem_raddr_o, output vmem_rdata_i);
endinterface

// File: rtl/vmem_scanout.sv
// rtl/vmem_scanout.sv - free-running raster timing with pixel-replicated framebuffer scan-out
// Optional feature: DISP_BORDER_EN forces a white one-pixel frame around the active area.
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 15
`endif

module vmem_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  vmem_scanout_if.master        vmem,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [11:0]           rgb_o,
  output logic                  frame_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int AW      = `VMEM_ADDRW;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] SCALE_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [AW-1:0] FB_W_A     = AW'(FB_W);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] vcnt_inc;
  logic [AW-1:0] row_base;
  logic          active;
  logic          in_hsync;
  logic          in_vsync;
  logic          first_px;

  logic [2:0] de_p;
  logic [2:0] hs_p;
  logic [2:0] vs_p;
  logic [2:0] fr_p;

  assign vcnt_inc = vcnt + 1'b1;
  assign active   = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign in_hsync = (hcnt >= HS_START) && (hcnt < HS_END);
  assign in_vsync = (vcnt >= VS_START) && (vcnt < VS_END);
  assign first_px = (hcnt == '0) && (vcnt == '0);

  // row_base tracks (vcnt>>SCALE_SHIFT)*FB_W by adding FB_W whenever a new framebuffer row begins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt     <= '0;
      vcnt     <= '0;
      row_base <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      if (vcnt == V_LAST) begin
        vcnt     <= '0;
        row_base <= '0;
      end else begin
        vcnt <= vcnt_inc;
        if ((vcnt_inc & SCALE_MASK) == '0)
          row_base <= row_base + FB_W_A;
      end
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vmem.vmem_raddr_o <= '0;
      de_p <= '0;
      hs_p <= '0;
      vs_p <= '0;
      fr_p <= '0;
    end else begin
      vmem.vmem_raddr_o <= active ? row_base + AW'(hcnt >> SCALE_SHIFT) : '0;
      de_p <= {de_p[1:0], active};
      hs_p <= {hs_p[1:0], in_hsync};
      vs_p <= {vs_p[1:0], in_vsync};
      fr_p <= {fr_p[1:0], first_px};
    end
  end

`ifdef DISP_BORDER_EN
  logic       border;
  logic [2:0] bd_p;

  assign border = active && ((hcnt == '0) || (hcnt == H_ACT - 1'b1) ||
                             (vcnt == '0) || (vcnt == V_ACT - 1'b1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bd_p <= '0;
    else       bd_p <= {bd_p[1:0], border};
  end
`endif

  // Output stage: flags have travelled alongside the 1+2 cycle address/memory latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_o <= ~SYNC_POL;
      vsync_o <= ~SYNC_POL;
      de_o    <= 1'b0;
      frame_o <= 1'b0;
      rgb_o   <= 12'h000;
    end else begin
      hsync_o <= hs_p[2] ? SYNC_POL : ~SYNC_POL;
      vsync_o <= vs_p[2] ? SYNC_POL : ~SYNC_POL;
      de_o    <= de_p[2];
      frame_o <= fr_p[2];
`ifdef DISP_BORDER_EN
      if (de_p[2] && bd_p[2])
        rgb_o <= 12'hFFF;
      else
`endif
      if (de_p[2])
        rgb_o <= {{4{vmem.vmem_rdata_i[2]}}, {4{vmem.vmem_rdata_i[1]}}, {4{vmem.vmem_rdata_i[0]}}};
      else
        rgb_o <= 12'h000;
    end
  end

endmodule

// File: tb/tb_vmem_scanout.sv
// tb/tb_vmem_scanout.sv - randomized scan-out bench against a position-based raster model
`ifndef VMEM_ADDRW
`define VMEM_ADDRW 15
`endif

module tb_vmem_scanout;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 1;
  localparam int S  = 1;
  localparam bit POL = 1'b0;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int SC  = 1 << S;
  localparam int FBW = HA >> S;
  localparam int FBN = FBW * (VA >> S);
  localparam int AW  = `VMEM_ADDRW;

  typedef struct packed {
    logic [AW-1:0] raddr;
    logic          hs;
    logic          vs;
    logic          de;
    logic          fr;
    logic [11:0]   rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_o, vsync_o, de_o, frame_o;
  logic [11:0] rgb_o;
  logic [2:0]  r1;
  logic [2:0]  mem [FBN];
  int          checks = 0;
  int          errors = 0;

  vmem_scanout_if vif ();

  vmem_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SCALE_SHIFT(S), .SYNC_POL(POL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .vmem(vif),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .rgb_o(rgb_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Two-clock read latency memory
  always @(posedge clk) begin
    r1 <= (int'(vif.vmem_raddr_o) < FBN) ? mem[int'(vif.vmem_raddr_o)] : 3'b000;
    vif.vmem_rdata_i <= r1;
  end

  function automatic logic [11:0] expand(logic [2:0] d);
    return {{4{d[2]}}, {4{d[1]}}, {4{d[0]}}};
  endfunction

  // Expected outputs n clocks after reset release, derived from raster position
  function automatic exp_t model(int n);
    exp_t e;
    int p, hc, vc;
    e.raddr = '0; e.hs = ~POL; e.vs = ~POL; e.de = 1'b0; e.fr = 1'b0; e.rgb = 12'h000;
    if (n >= 1) begin
      p = n - 1; hc = p % HT; vc = (p / HT) % VT;
      if (hc < HA && vc < VA) e.raddr = AW'((vc >> S) * FBW + (hc >> S));
    end
    if (n >= 4) begin
      p = n - 4; hc = p % HT; vc = (p / HT) % VT;
      e.hs = (hc >= HA + HFP && hc < HA + HFP + HSY) ? POL : ~POL;
      e.vs = (vc >= VA + VFP && vc < VA + VFP + VSY) ? POL : ~POL;
      e.de = (hc < HA && vc < VA);
      e.fr = (hc == 0 && vc == 0);
      if (e.de) e.rgb = expand(mem[(vc >> S) * FBW + (hc >> S)]);
`ifdef DISP_BORDER_EN
      if (e.de && (hc == 0 || hc == HA - 1 || vc == 0 || vc == VA - 1)) e.rgb = 12'hFFF;
`endif
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.raddr = vif.vmem_raddr_o; o.hs = hsync_o; o.vs = vsync_o;
    o.de = de_o; o.fr = frame_o; o.rgb = rgb_o;
    return o;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < FBN; i++) mem[i] = 3'($urandom);
  endtask

  task automatic fill_const(logic [2:0] v);
    for (int i = 0; i < FBN; i++) mem[i] = v;
  endtask

  task automatic start_run();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o, e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    o = observed();
    e = '{raddr: '0, hs: ~POL, vs: ~POL, de: 1'b0, fr: 1'b0, rgb: 12'h000};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", o, e);
    end
  endtask

  task automatic test_scan();
    exp_t o, e;
    fill_random();
    start_run();
    for (int n = 0; n < 2 * HT * VT + 8; n++) begin
      o = observed();
      e = model(n);
      checks++;
      if (o !== e) begin
        errors++;
        if (errors < 20) $display("FAIL scan n=%0d: got %h expected %h", n, o, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_timing();
    int n = 0, cyc = 0, de_cnt = 0, hs_len = 0, hs_fall = -1, vs_len = 0, vs_start = -1;
    fill_random();
    start_run();
    while (!frame_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL first_frame_latency: got %0d expected 4", n); end
    do begin
      de_cnt += int'(de_o);
      if (cyc < HT && hsync_o === POL) begin
        hs_len++;
        if (hs_fall < 0) hs_fall = cyc;
      end
      if (vsync_o === POL) begin
        vs_len++;
        if (vs_start < 0) vs_start = cyc;
      end
      @(negedge clk);
      cyc++;
    end while (!frame_o && cyc < 3 * HT * VT);
    checks += 6;
    if (cyc !== HT * VT) begin errors++; $display("FAIL frame_period: got %0d expected %0d", cyc, HT * VT); end
    if (de_cnt !== HA * VA) begin errors++; $display("FAIL de_count: got %0d expected %0d", de_cnt, HA * VA); end
    if (hs_fall !== HA + HFP) begin errors++; $display("FAIL hsync_start: got %0d expected %0d", hs_fall, HA + HFP); end
    if (hs_len !== HSY) begin errors++; $display("FAIL hsync_width: got %0d expected %0d", hs_len, HSY); end
    if (vs_start !== (VA + VFP) * HT) begin errors++; $display("FAIL vsync_start: got %0d expected %0d", vs_start, (VA + VFP) * HT); end
    if (vs_len !== VSY * HT) begin errors++; $display("FAIL vsync_width: got %0d expected %0d", vs_len, VSY * HT); end
  endtask

  task automatic test_pattern();
    int p, hc, vc;
    logic [11:0] want;
    fill_const(3'b000);
    mem[0] = 3'b100;
    mem[FBW + 1] = 3'b011;
    start_run();
    for (int n = 0; n < 4 + 2 * SC * HT; n++) begin
      if (n >= 4) begin
        p = n - 4; hc = p % HT; vc = p / HT;
        if (hc < 2 * SC && vc < 2 * SC && hc > 0 && vc > 0 || (hc < 2 * SC && vc < 2 * SC)) begin
          if (hc < SC && vc < SC) want = 12'hF00;
          else if (hc >= SC && vc >= SC) want = 12'h0FF;
          else want = 12'h000;
`ifdef DISP_BORDER_EN
          if (hc == 0 || vc == 0) want = 12'hFFF;
`endif
          checks++;
          if (rgb_o !== want) begin
            errors++;
            $display("FAIL pattern (%0d,%0d): got %h expected %h", hc, vc, rgb_o, want);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blank_ones();
    int p, hc, vc;
    int last = (VA - 1) * HT + HA;
    fill_const(3'b111);
    start_run();
    for (int n = 0; n < HT * VT + 4; n++) begin
      if (n == last) begin
        checks++;
        if (vif.vmem_raddr_o !== AW'(FBN - 1)) begin
          errors++; $display("FAIL raddr_last_active: got %0d expected %0d", vif.vmem_raddr_o, FBN - 1);
        end
      end
      if (n == last + 1) begin
        checks++;
        if (vif.vmem_raddr_o !== '0) begin
          errors++; $display("FAIL raddr_after_active: got %0d expected 0", vif.vmem_raddr_o);
        end
      end
      if (n >= 4) begin
        p = n - 4; hc = p % HT; vc = (p / HT) % VT;
        if (!(hc < HA && vc < VA)) begin
          checks++;
          if (rgb_o !== 12'h000 || de_o !== 1'b0) begin
            errors++;
            if (errors < 20) $display("FAIL blank_rgb (%0d,%0d): got %h/%b expected 000/0", hc, vc, rgb_o, de_o);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    exp_t o, e;
    fill_random();
    start_run();
    repeat (200 * 0 + 5 * HT + 10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    o = observed();
    e = '{raddr: '0, hs: ~POL, vs: ~POL, de: 1'b0, fr: 1'b0, rgb: 12'h000};
    checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %h expected %h", o, e); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 2 * HT; n++) begin
      o = observed();
      e = model(n);
      checks++;
      if (o !== e) begin
        errors++;
        if (errors < 20) $display("FAIL post_reset n=%0d: got %h expected %h", n, o, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vif.vmem_rdata_i = 3'b000;
    r1 = 3'b000;
    test_reset();
    test_scan();
    test_frame_timing();
    test_pattern();
    test_blank_ones();
    test_mid_reset();
    test_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_scanout.md
VMEM_SCANOUT -- requirements
Module: vmem_scanout

Interface
- REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
- REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch/sync/back porch in clocks.
- REQ-003 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
- REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, 10/2/33, vertical porch/sync in lines.
- REQ-005 SHALL have parameter SCALE_SHIFT, 2, log2 of the pixel replication factor. FB_W = H_ACTIVE>>SCALE_SHIFT.
- REQ-006 SHALL have parameter SYNC_POL, 0, active sync level. 0 = active-low.
- REQ-007 SHALL have port clk_i, input, 1, sole clock. Reset is asynchronous and active-high.
- REQ-008 SHALL have port rst_i, input, 1, asynchronous active-high reset.
- REQ-009 SHALL have port vmem_raddr_o, output, `VMEM_ADDRW, registered framebuffer read address.
- REQ-010 SHALL have port vmem_rdata_i, input, 3, pixel {R,G,B}, returned 2 clocks after the address is presented.
- REQ-011 SHALL have port hsync_o / vsync_o, output, 1 each, registered sync signals.
- REQ-012 SHALL have port de_o, output, 1, registered data enable.
- REQ-013 SHALL have port rgb_o, output, 12, registered {R4,G4,B4}.
- REQ-014 SHALL have port frame_o, output, 1, one-clock pulse on the first active pixel of each frame.

Function
- REQ-015 SHALL keep hcnt in 0..H_TOTAL-1 and vcnt in 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is defined likewise.
- REQ-016 hcnt SHALL wrap from H_TOTAL-1 to 0 and increment vcnt in the same clock. At (H_TOTAL-1, V_TOTAL-1) both counters SHALL wrap to 0 in one clock.
- REQ-017 The active region SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE. The sync region SHALL be hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), with the vertical region defined likewise on vcnt.
- REQ-018 When in the active region, vmem_raddr_o SHALL equal (vcnt>>SCALE_SHIFT)*FB_W + (hcnt>>SCALE_SHIFT), truncated to `VMEM_ADDRW, registered one clock after the counter state. Outside the active region it SHALL equal 0. No multiplier SHALL be used; the row base SHALL be accumulated.
- REQ-019 Active, hsync, vsync and frame-start flags SHALL be delayed through a 4-stage pipeline so that all outputs for counter state t appear in cycle t+4: 1 cycle for the address register, 2 for vmem, 1 for the output register.
- REQ-020 rgb_o SHALL be {{4{d[2]}},{4{d[1]}},{4{d[0]}}} from vmem_rdata_i when the delayed active flag is 1, and 12'h000 otherwise.
- REQ-021 hsync_o and vsync_o SHALL equal SYNC_POL inside their sync regions and ~SYNC_POL elsewhere.
- REQ-022 frame_o SHALL be 1 only in the cycle where de_o carries pixel (0,0).
- REQ-023 The block SHALL have no back-pressure. Scan-out SHALL be free-running, and vmem writes SHALL never stall it.

Reset
- REQ-024 While rst_i=1: hcnt=vcnt=0, all pipeline stages cleared, vmem_raddr_o=0, de_o=0, rgb_o=0, frame_o=0, and hsync_o=vsync_o=~SYNC_POL.
- REQ-025 Reset asserted mid-frame SHALL take effect immediately and asynchronously. After release, the first clock SHALL see counters (0,0), and de_o/frame_o SHALL first assert 4 clocks later.

Configuration
- REQ-026 With DISP_BORDER_EN defined, active pixels with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 SHALL output rgb_o=12'hFFF regardless of vmem data.
- REQ-027 Without DISP_BORDER_EN, all active pixels SHALL come from vmem per REQ-020, and the border logic SHALL be absent.

Verification
- REQ-028 Release reset, then count clocks between frame_o pulses -> exactly 800*525=420000. Count de_o-high clocks per frame -> 307200.
- REQ-029 Line timing -> hsync_o low for 96 clocks, starting 656 clocks after the first de_o of the line. vsync_o low for 2 lines starting at line 490.
- REQ-030 vmem model: address 0 = 3'b100, address 161 = 3'b011, others 0 -> pixels (0..3, 0..3) give rgb_o=12'hF00, and pixels (4..7, 4..7) give 12'h0FF.
- REQ-031 Assert rst_i at hcnt=300, vcnt=200 for 3 clocks -> outputs return to reset values in the same cycle, and frame_o occurs 4 clocks after release.
- REQ-032 Check vmem_raddr_o at hcnt=639, vcnt=479 -> 19199. At hcnt=640 -> 0. rgb_o during blanking is 0 even with vmem all 3'b111.
- REQ-033 With DISP_BORDER_EN and vmem all 0 -> rgb_o=12'hFFF on rows 0/479 and columns 0/639 only.
